// File: rtl/tl_cntr.sv
// Two-street traffic-light controller (Moore FSM) for streets A and B.
// Optional feature macro: TL_YELLOW_HOLD_EN. When it is defined, each yellow
// phase is stretched to YELLOW_CYCLES clocks by an 8-bit counter. When it is
// undefined, each yellow phase lasts exactly one clock.
//
// state | meaning
// S0    | A green,  B red    (held while Ta=1)
// S1    | A yellow, B red
// S2    | A red,    B green  (held while Tb=1)
// S3    | A red,    B yellow
module tl_cntr #(
  parameter int YELLOW_CYCLES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Ta,
  input  logic       Tb,
  output logic [1:0] La,
  output logic [1:0] Lb
);

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } state_t;

  localparam logic [1:0] GREEN  = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] RED    = 2'b10;

  state_t state;
  state_t state_next;
  logic   yellow_done;
  logic   s1_next;
  logic   s0_next;

`ifdef TL_YELLOW_HOLD_EN
  localparam logic [7:0] YEL_LAST = 8'(YELLOW_CYCLES - 1);

  logic [7:0] yel_cnt;

  // Count clocks spent in a yellow state; clear on the advancing edge and outside yellow.
  always_ff @(posedge clk) begin
    if (reset) begin
      yel_cnt <= 8'd0;
    end else if ((state == S1) || (state == S3)) begin
      yel_cnt <= yellow_done ? 8'd0 : yel_cnt + 8'd1;
    end else begin
      yel_cnt <= 8'd0;
    end
  end

  assign yellow_done = (yel_cnt == YEL_LAST);
`else
  assign yellow_done = 1'b1;
`endif

  // State register; reset wins over sensors and any yellow count.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S0;
    end else begin
      state <= state_next;
    end
  end

  // Gate-level next state; the yellow states (state[0]=1) wait for the hold to expire.
  always_comb begin
    state_next = state;
    s1_next    = state[1] ^ state[0];
    s0_next    = (~state[0] & ~state[1] & ~Ta) | (~state[0] & state[1] & ~Tb);
    if (state[0] && !yellow_done) begin
      state_next = state;
    end else begin
      state_next = state_t'({s1_next, s0_next});
    end
  end

  // Lamp decode from state only; at most one street is ever non-red.
  always_comb begin
    La = RED;
    Lb = RED;
    case (state)
      S0: begin La = GREEN;  Lb = RED;    end
      S1: begin La = YELLOW; Lb = RED;    end
      S2: begin La = RED;    Lb = GREEN;  end
      S3: begin La = RED;    Lb = YELLOW; end
      default: begin La = RED; Lb = RED; end
    endcase
  end

endmodule

// File: tb/tb_tl_cntr.sv
// Directed bench for tl_cntr: lamp codes checked after every clock edge
// against hand-derived values. Yellow length follows TL_YELLOW_HOLD_EN.
module tb_tl_cntr;

`ifdef TL_YELLOW_HOLD_EN
  localparam int YC = 3;
`else
  localparam int YC = 1;
`endif

  // {La, Lb} expected codes
  localparam logic [3:0] A_GRN = 4'b0010;
  localparam logic [3:0] A_YEL = 4'b0110;
  localparam logic [3:0] B_GRN = 4'b1000;
  localparam logic [3:0] B_YEL = 4'b1001;

  logic       clk = 1'b0;
  logic       reset;
  logic       Ta;
  logic       Tb;
  logic [1:0] La;
  logic [1:0] Lb;

  int errors = 0;
  int checks = 0;

  tl_cntr #(.YELLOW_CYCLES(3)) dut (
    .clk   (clk),
    .reset (reset),
    .Ta    (Ta),
    .Tb    (Tb),
    .La    (La),
    .Lb    (Lb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got La/Lb=%b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic step_chk(input string tag, input logic [3:0] exp);
    step();
    chk(tag, {La, Lb}, exp);
  endtask

  initial begin
    reset = 1'b1; Ta = 1'b1; Tb = 1'b0;
    step_chk("reset", A_GRN);

    // A holds green while Ta=1
    reset = 1'b0;
    for (int i = 0; i < 3; i++) step_chk("a_hold", A_GRN);

    // Tb ignored in S0
    Tb = 1'b1; step_chk("s0_tb_ign1", A_GRN);
    Tb = 1'b0; step_chk("s0_tb_ign2", A_GRN);

    // A handoff; sensors toggled during yellow must not matter
    Ta = 1'b0;
    for (int i = 0; i < YC; i++) begin
      step_chk("a_yellow", A_YEL);
      Ta = ~Ta; Tb = ~Tb;
    end
    Tb = 1'b1;
    step_chk("b_green", B_GRN);

    // B holds green while Tb=1; Ta ignored in S2
    for (int i = 0; i < 3; i++) begin
      Ta = ~Ta;
      step_chk("b_hold", B_GRN);
    end

    // B handoff and return to A
    Tb = 1'b0;
    for (int i = 0; i < YC; i++) begin
      step_chk("b_yellow", B_YEL);
      Ta = ~Ta; Tb = ~Tb;
    end
    Ta = 1'b1; Tb = 1'b0;
    step_chk("back_a", A_GRN);

    // Free-running cycle, no traffic
    Ta = 1'b0; Tb = 1'b0;
    for (int i = 0; i < YC; i++) step_chk("free_ay", A_YEL);
    step_chk("free_bg", B_GRN);
    for (int i = 0; i < YC; i++) step_chk("free_by", B_YEL);
    step_chk("free_ag", A_GRN);

    // Reset in S3
    for (int i = 0; i < YC; i++) step();
    step_chk("pre_s3_bg", B_GRN);
    step_chk("in_s3", B_YEL);
    reset = 1'b1;
    step_chk("reset_s3", A_GRN);

    // Reset in S2 with Tb=1
    reset = 1'b0; Ta = 1'b0; Tb = 1'b1;
    for (int i = 0; i < YC; i++) step();
    step_chk("in_s2", B_GRN);
    reset = 1'b1;
    step_chk("reset_s2", A_GRN);
    reset = 1'b0; Ta = 1'b1; Tb = 1'b0;
    step_chk("after_reset_s2", A_GRN);

`ifdef TL_YELLOW_HOLD_EN
    // Reset during the 2nd yellow clock, then a full-length yellow follows
    Ta = 1'b0;
    step_chk("hy_1", A_YEL);
    step_chk("hy_2", A_YEL);
    reset = 1'b1;
    step_chk("hy_reset", A_GRN);
    reset = 1'b0;
    for (int i = 0; i < YC; i++) step_chk("hy_restart", A_YEL);
    step_chk("hy_bg", B_GRN);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
